// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the arbiter state encoding,
// default bit timing, and the frame-length helper used by uart_send,
// uart_recv and uart_tx_arb.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no lock, waiting for any requester
        ST_HOLD = 2'd1,   // lock held, waiting for the owner's next byte
        ST_WAIT = 2'd2    // a frame is on the line, inputs ignored
    } arb_state_t;

    localparam int DEFAULT_CYCLES_PER_BIT = 10417;  // 100 MHz / 9600 baud
    localparam int DEFAULT_FRAME_BITS     = 10;     // start + 8 data + stop

    // Clock cycles one frame occupies, including the idle guard after it.
    function automatic int frame_cycles(input int cycles_per_bit,
                                        input int frame_bits,
                                        input int guard_cycles);
        return cycles_per_bit * frame_bits + guard_cycles;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// ---------------------------------------------------------------------------
// uart_frame_timer
// Loadable down-counter. A load sets the count; afterwards it decrements
// once per cycle and parks at zero. done is high while the count is zero,
// so a value of N-1 loaded at an edge makes done rise exactly N cycles later.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   CNT_W-bit value to load
//   done      out  count is zero
// ---------------------------------------------------------------------------
module uart_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one uart_send between two byte requesters.
// A granted requester keeps the transmitter until it sends a byte marked
// last, or until it leaves valid low for LOCK_TIMEOUT cycles while holding
// the lock. uart_send has no busy output, so every frame is timed here and
// the next valid pulse is issued only after FRAME_CYCLES have elapsed.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/data/last (N=0,1)  requester byte, held until reqN_ready
//   reqN_ready                    1-cycle pulse: byte accepted
//   send_valid                    1-cycle pulse to uart_send
//   send_data                     byte to uart_send, stable until next accept
//   busy                          arbiter state is not IDLE
//   owner                         current / last granted requester
// ---------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int FRAME_BITS     = DEFAULT_FRAME_BITS,
    parameter int GUARD_CYCLES   = 2,
    parameter int LOCK_TIMEOUT   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       send_valid,
    output logic [7:0] send_data,
    output logic       busy,
    output logic       owner
);

    localparam int FRAME_CYCLES = frame_cycles(CYCLES_PER_BIT, FRAME_BITS, GUARD_CYCLES);
    localparam int CNT_W        = $clog2(max_int(FRAME_CYCLES, LOCK_TIMEOUT) + 1);

    // Timed states last exactly their cycle count: WAIT holds for
    // FRAME_CYCLES cycles after the accept edge, HOLD for LOCK_TIMEOUT.
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t state_q, state_d;

    logic       owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic       last_q, last_d;
    logic       send_valid_q, send_valid_d;
    logic [7:0] send_data_q, send_data_d;
    logic       req0_ready_q, req0_ready_d;
    logic       req1_ready_q, req1_ready_d;
    logic       busy_q, busy_d;

    logic             accept;
    logic             grant;
    logic             owner_valid;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_done;

    // One timer serves both the frame gap and the lock timeout; the two
    // are never needed at the same time.
    uart_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .done     (timer_done)
    );

    assign owner_valid = owner_q ? req1_valid : req0_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        grant   = owner_q;
        case (state_q)
            ST_IDLE: begin
                // The pointer only breaks ties; a lone requester always wins.
                if (req0_valid && req1_valid) begin
                    accept = 1'b1;
                    grant  = ptr_q;
                end else if (req0_valid) begin
                    accept = 1'b1;
                    grant  = 1'b0;
                end else if (req1_valid) begin
                    accept = 1'b1;
                    grant  = 1'b1;
                end
            end
            ST_HOLD: begin
                // Only the lock owner is looked at while the lock is held.
                if (owner_valid) begin
                    accept = 1'b1;
                    grant  = owner_q;
                end else if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (timer_done) begin
                    state_d = last_q ? ST_IDLE : ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_WAIT;
        end
    end

    // Registered outputs, datapath and timer control
    always_comb begin
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        last_d         = last_q;
        send_data_d    = send_data_q;
        send_valid_d   = accept;
        req0_ready_d   = accept && !grant;
        req1_ready_d   = accept && grant;
        busy_d         = (state_d != ST_IDLE);
        timer_load     = 1'b0;
        timer_load_val = FRAME_LOAD;

        if (accept) begin
            owner_d        = grant;
            send_data_d    = grant ? req1_data : req0_data;
            last_d         = grant ? req1_last : req0_last;
            timer_load     = 1'b1;
            timer_load_val = FRAME_LOAD;
        end else if (state_q == ST_WAIT && timer_done && !last_q) begin
            timer_load     = 1'b1;
            timer_load_val = LOCK_LOAD;
        end

        // Returning to IDLE means the lock is gone (packet end or timeout):
        // hand tie-break priority to the other requester.
        if (!accept && state_q != ST_IDLE && state_d == ST_IDLE) begin
            ptr_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            ptr_q        <= 1'b0;
            last_q       <= 1'b0;
            send_valid_q <= 1'b0;
            send_data_q  <= 8'h00;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            last_q       <= last_d;
            send_valid_q <= send_valid_d;
            send_data_q  <= send_data_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign send_valid = send_valid_q;
    assign send_data  = send_data_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter that shares the single uart_send transmitter between two byte-stream requesters. Requesters present bytes with a last-of-packet flag. A granted requester keeps the transmitter until its packet ends or it stalls past a timeout. uart_send has no ready/busy output, so the arbiter times each frame itself and issues a new valid pulse only after the previous frame has fully left the line.

Parameters:
CYCLES_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); must match uart_send.
FRAME_BITS, 10, bits per frame (start + 8 data + stop).
GUARD_CYCLES, 2, idle cycles added after each frame.
LOCK_TIMEOUT, 1000000, cycles an owner may leave valid low mid-packet before the lock is dropped.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 has a byte; held until req0_ready
req0_data  in  8  requester 0 byte
req0_last  in  1  byte is last of packet
req0_ready  out  1  1-cycle pulse: byte accepted
req1_valid  in  1  as req0
req1_data  in  8  as req0
req1_last  in  1  as req0
req1_ready  out  1  as req0
send_valid  out  1  1-cycle pulse to uart_send valid
send_data  out  8  to uart_send data; stable from send_valid until next accept
busy  out  1  high whenever state is not IDLE
owner  out  1  current/last granted requester index

Behaviour:
- Reset values: send_valid=0, send_data=0, req*_ready=0, busy=0, owner=0, rr pointer=0, state=IDLE, lock=0, counters=0. All outputs are registered.
- FRAME_CYCLES = CYCLES_PER_BIT*FRAME_BITS + GUARD_CYCLES. Counter width is $clog2(max(FRAME_CYCLES,LOCK_TIMEOUT)+1).
- States: IDLE, HOLD, WAIT.
- IDLE: if exactly one reqN_valid is high, grant N. If both are high, grant the rr pointer. Accept in cycle t: owner<=N, send_data<=reqN_data, last_q<=reqN_last. At t+1, reqN_ready=1 and send_valid=1 for exactly one cycle, and the state is WAIT. Accept latency is 1 cycle.
- WAIT: the frame counter loads FRAME_CYCLES at accept and decrements once per cycle. Requester inputs are ignored. At zero:
  - If last_q=1: lock cleared, pointer<=~owner, go to IDLE.
  - If last_q=0: lock held, go to HOLD, timeout counter cleared.
- HOLD: only the owner's valid is sampled; the other requester waits regardless of its valid. Owner valid high gives the same accept sequence as IDLE, then WAIT. Timeout counter reaching LOCK_TIMEOUT gives lock release, pointer<=~owner, IDLE, with no byte sent.
- Minimum spacing between send_valid pulses is FRAME_CYCLES+1 cycles. Back-to-back packets from one requester get no extra gap.
- Fairness: after each packet end or timeout, the other requester has priority. A single active requester is served repeatedly, because the pointer only breaks ties.
- The ready pulse is the only acceptance indication. A requester that drops valid before ready loses nothing because nothing was accepted.
- Reset mid-frame: all state is cleared immediately. uart_send shares rst, so the line returns idle. A partially sent packet is lost, with no replay.
- last=1 on a single byte is a one-byte packet; the lock is never held.

Decomposition:
- Package uart_pkg: state enum (IDLE/HOLD/WAIT), default CYCLES_PER_BIT, FRAME_BITS, and a FRAME_CYCLES function shared with uart_send/uart_recv.
- Sub-module uart_frame_timer: loadable down-counter with a done flag, reused for both frame and lock-timeout counting.
- Top-level integration: uart_tx_arb sits between uart_top/other sources and uart_send.

Test Plan (CYCLES_PER_BIT=4, FRAME_BITS=10, GUARD_CYCLES=2, so FRAME_CYCLES=42; LOCK_TIMEOUT=100):
- Single byte: req0 sends 0x55 with last=1. Expect req0_ready and send_valid at cycle t+1, send_data=0x55, busy low 42 cycles after the pulse, owner=0.
- Packet lock: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) while req1_valid is held high. Expect send order 0x41,0x42,0x43 then req1's byte, with pulses spaced ≥43 cycles.
- Simultaneous after reset: both valid, req0=0xA0, req1=0xB1, each last=1. Expect 0xA0 first (pointer 0), then 0xB1. Repeat both valid: 0xA0 before 0xB1 again, since the pointer flips after each packet.
- Timeout: req1 sends 0x10 with last=0 then goes silent while req0 is valid. Expect req0's byte sent exactly 100 cycles after HOLD entry. No req1_ready in between.
- Reset mid-frame: assert rst 10 cycles after send_valid during a 2-byte packet. Expect all outputs 0 immediately, the second byte not sent, and the next request accepted normally.
- Loopback: uart_recv → arbiter → uart_send with 0xC3 injected on uart_rx. Expect a 0xC3 frame decoded on uart_tx.
